// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: shared display widths, reader state encoding and default frame size
package frame_reader_pkg;
  localparam int PIX_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEF_WIDTH = 128;
  localparam int DEF_HEIGHT = 128;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/frame_reader_raster_counter.sv
// frame_reader_raster_counter: raster-order col/row counters with wrap and last-pixel flags
module frame_reader_raster_counter
  import frame_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic              last_col,
  output logic              last_frame
);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(HEIGHT - 1);
  assign last_col = col == COL_MAX;
  assign last_frame = last_col && row == ROW_MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= last_col ? (row == ROW_MAX ? '0 : row + 1'b1) : row;
    end
endmodule

// File: rtl/frame_reader.sv
// frame_reader: scans a pixel-memory window in raster order and streams it over valid/ready
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int X0 = 0,
  parameter int Y0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr_x,
  output logic [ADDR_W-1:0] ram_addr_y,
  input  logic [PIX_W-1:0]  ram_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy
);
  if (WIDTH < 1 || HEIGHT < 1 || X0 < 0 || Y0 < 0 || X0 + WIDTH > 256 || Y0 + HEIGHT > 256)
    begin : g_bad_geometry
      $error("frame_reader: window does not fit the 8-bit address space");
    end
  state_t state, next;
  logic [ADDR_W-1:0] col, row;
  logic last_col, last_frame, load, accept;
  assign load = state == FETCH && (!pix_valid || pix_ready);
  assign accept = pix_valid && pix_ready;
  assign busy = state != IDLE;
  assign ram_addr_x = ADDR_W'(X0) + col;
  assign ram_addr_y = ADDR_W'(Y0) + row;
  frame_reader_raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == IDLE && start),
    .adv        (load),
    .col        (col),
    .row        (row),
    .last_col   (last_col),
    .last_frame (last_frame)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (state == IDLE && start) next = FETCH;
    else if (state == FETCH && load && last_frame) next = DRAIN;
    else if (state == DRAIN && accept) next = IDLE;
  end
  // Markers are latched with the pixel so they stay aligned through stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_data <= '0;
      pix_valid <= 1'b0;
      pix_sof <= 1'b0;
      pix_eol <= 1'b0;
      pix_eof <= 1'b0;
    end else if (load) begin
      pix_data <= ram_data;
      pix_valid <= 1'b1;
      pix_sof <= col == '0 && row == '0;
      pix_eol <= last_col;
      pix_eof <= last_frame;
    end else if (accept) begin
      pix_valid <= 1'b0;
      pix_sof <= 1'b0;
      pix_eol <= 1'b0;
      pix_eof <= 1'b0;
    end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: table-driven and randomized checks of frame_reader against a raster model
module tb_frame_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0, ready_a = 1'b0, val_a, sof_a, eol_a, eof_a, busy_a;
  logic [7:0] ax, ay;
  logic [15:0] da;
  frame_reader #(.WIDTH(4), .HEIGHT(3), .X0(10), .Y0(20)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ram_addr_x(ax), .ram_addr_y(ay),
    .ram_data({ay, ax}), .pix_data(da), .pix_valid(val_a), .pix_ready(ready_a),
    .pix_sof(sof_a), .pix_eol(eol_a), .pix_eof(eof_a), .busy(busy_a));

  logic start_b = 1'b0, ready_b = 1'b0, val_b, sof_b, eol_b, eof_b, busy_b;
  logic [7:0] bx, by;
  logic [15:0] db;
  frame_reader #(.WIDTH(1), .HEIGHT(1), .X0(5), .Y0(7)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ram_addr_x(bx), .ram_addr_y(by),
    .ram_data({by, bx}), .pix_data(db), .pix_valid(val_b), .pix_ready(ready_b),
    .pix_sof(sof_b), .pix_eol(eol_b), .pix_eof(eof_b), .busy(busy_b));

  logic start_c = 1'b0, ready_c = 1'b0, val_c, sof_c, eol_c, eof_c, busy_c;
  logic [7:0] cx, cy;
  logic [15:0] dc;
  frame_reader dut_c (
    .clk(clk), .rst(rst), .start(start_c), .ram_addr_x(cx), .ram_addr_y(cy),
    .ram_data({cy, cx}), .pix_data(dc), .pix_valid(val_c), .pix_ready(ready_c),
    .pix_sof(sof_c), .pix_eol(eol_c), .pix_eof(eof_c), .busy(busy_c));

  logic [18:0] cur_a, cur_b, cur_c;
  assign cur_a = {da, sof_a, eol_a, eof_a};
  assign cur_b = {db, sof_b, eol_b, eof_b};
  assign cur_c = {dc, sof_c, eol_c, eof_c};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Beat i of a raster scan: {pixel={y,x}, sof, eol, eof}
  function automatic logic [18:0] beat(input int i, input int w, input int h, input int x0, input int y0);
    return {8'(y0 + i / w), 8'(x0 + i % w), i == 0, i % w == w - 1, i == w * h - 1};
  endfunction

  typedef struct {
    int mode;
    bit poke;
    int abort;
    string name;
  } vec_t;

  vec_t vecs[6];
  logic [18:0] exp_a[12];

  task automatic run_frame(input vec_t v);
    int idx = 0, cyc = 0, first = -1, last = -1;
    logic stall = 1'b0;
    logic [18:0] held = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({v.name, " latency"}, {busy_a, val_a}, 2'b10);
    while (idx < 12 && cyc < 300) begin
      ready_a = v.mode == 0 ? 1'b1 : v.mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      start_a = v.poke && val_a && (idx == 4 || (ready_a && eof_a));
      if (stall) chk({v.name, " stall hold"}, {cur_a, val_a}, {held, 1'b1});
      if (val_a && ready_a) begin
        if (first < 0) first = cyc;
        last = cyc;
        chk($sformatf("%s beat%0d", v.name, idx), cur_a, exp_a[idx]);
        idx++;
      end
      stall = val_a && !ready_a;
      held = cur_a;
      if (v.abort != 0 && idx == v.abort) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk({v.name, " async reset"}, {val_a, busy_a, ax, ay}, {2'b00, 8'd10, 8'd20});
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    chk({v.name, " accept count"}, idx, 12);
    if (v.mode == 0) chk({v.name, " no gaps"}, last - first, 11);
    chk({v.name, " idle after eof"}, {busy_a, val_a}, 2'b00);
    ready_a = 1'b0;
    repeat (3) @(negedge clk);
    chk({v.name, " stays idle"}, {busy_a, val_a}, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) exp_a[i] = beat(i, 4, 3, 10, 20);
    vecs[0] = '{0, 1'b0, 0, "nostall"};
    vecs[1] = '{1, 1'b0, 0, "toggle"};
    vecs[2] = '{0, 1'b1, 0, "poke"};
    vecs[3] = '{2, 1'b0, 0, "random"};
    vecs[4] = '{0, 1'b0, 6, "abort"};
    vecs[5] = '{2, 1'b0, 0, "after_abort"};
    #2;
    chk("reset outputs", {val_a, busy_a, sof_a, eol_a, eof_a, da, ax, ay},
        {5'b0, 16'h0000, 8'd10, 8'd20});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) run_frame(vecs[k]);

    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ready_b = 1'b1;
    chk("1x1 latency", {busy_b, val_b}, 2'b10);
    @(negedge clk);
    chk("1x1 beat", {val_b, cur_b}, {1'b1, 16'h0705, 3'b111});
    @(negedge clk);
    chk("1x1 idle", {busy_b, val_b}, 2'b00);

    begin
      int n = 0, errs = 0, first = -1, last = -1;
      logic [18:0] last_beat = '0;
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      ready_c = 1'b1;
      for (int cyc = 0; cyc < 20000 && n < 16384; cyc++) begin
        if (val_c) begin
          if (first < 0) first = cyc;
          last = cyc;
          last_beat = cur_c;
          if (cur_c !== beat(n, 128, 128, 0, 0)) errs++;
          n++;
        end
        @(negedge clk);
      end
      chk("128x128 count", n, 16384);
      chk("128x128 beat errors", errs, 0);
      chk("128x128 no gaps", last - first, 16383);
      chk("128x128 last beat", last_beat, {16'h7F7F, 3'b011});
      chk("128x128 idle", {busy_c, val_c}, 2'b00);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
